// File: rtl/stopwatch_pkg.sv
// Shared types and helpers for the tick-driven mm:ss stopwatch.
// Contents: FSM state encoding, BCD time record, seven-segment decode.
// Pure declarations, no logic and no timing.
package stopwatch_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2
  } state_t;

  localparam int BCD_W = 4;

  localparam logic [2:0] SEC_TENS_MAX = 3'd5;

  // Field order matches the 16-bit digits bus, most significant first.
  typedef struct packed {
    logic [BCD_W-1:0] min_tens;
    logic [BCD_W-1:0] min_ones;
    logic [BCD_W-1:0] sec_tens;
    logic [BCD_W-1:0] sec_ones;
  } bcd_time_t;

  // BCD to active-low segments, bit order gfedcba; non-BCD codes blank the digit.
  function automatic logic [6:0] seg7(input logic [BCD_W-1:0] bcd);
    logic [6:0] s;
    s = 7'b1111111;
    case (bcd)
      4'd0: s = 7'b1000000;
      4'd1: s = 7'b1111001;
      4'd2: s = 7'b0100100;
      4'd3: s = 7'b0110000;
      4'd4: s = 7'b0011001;
      4'd5: s = 7'b0010010;
      4'd6: s = 7'b0000010;
      4'd7: s = 7'b1111000;
      4'd8: s = 7'b0000000;
      4'd9: s = 7'b0010000;
      default: s = 7'b1111111;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/tick_edge_sync.sv
// Purpose: 2-flop synchronizer on an asynchronous level, plus rising-edge pulse.
// Latency: d_in sampled high at edge k -> pulse high between edges k+1 and k+2.
// Backpressure: none; one pulse per rising edge, a held-high input gives no more.
//
// Ports: c (clock), reset (async, active-low), d_in (async level),
//        pulse (one-cycle, combinational from s2/s3).
module tick_edge_sync (
  input  logic c,
  input  logic reset,
  input  logic d_in,
  output logic pulse
);

  logic s1, s2, s3;

  always_ff @(posedge c or negedge reset) begin
    if (!reset) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= d_in;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign pulse = s2 & ~s3;

endmodule

// File: rtl/tick_stopwatch.sv
// Purpose: mm:ss BCD stopwatch advanced by edges of the divided clock tick_in.
// Latency: tick_in sampled high at edge k -> digits updated at edge k+2.
// Backpressure: none; start_stop/clear are single-cycle pulses, clear wins.
//
// Ports: c, reset (async active-low), tick_in (async level), start_stop, clear,
//        running, digits {min_tens,min_ones,sec_tens,sec_ones}, wrap (1-cycle),
//        an/seg (active-low display scan).
// Macro TICK_STOPWATCH_SEG_EN enables the multiplexed display scan; otherwise
// an/seg are tied off (all digits and segments dark).
module tick_stopwatch
  import stopwatch_pkg::*;
#(
  parameter int MIN_LIMIT = 59,
  parameter int SCAN_BITS = 16
) (
  input  logic        c,
  input  logic        reset,
  input  logic        tick_in,
  input  logic        start_stop,
  input  logic        clear,
  output logic        running,
  output logic [15:0] digits,
  output logic        wrap,
  output logic [3:0]  an,
  output logic [6:0]  seg
);

  if (MIN_LIMIT < 1 || MIN_LIMIT > 99 || SCAN_BITS < 0) begin : g_param_check
    $error("tick_stopwatch: MIN_LIMIT must be 1..99 and SCAN_BITS non-negative");
  end

  localparam logic [BCD_W-1:0] ST_MAX = BCD_W'(SEC_TENS_MAX);
  localparam logic [BCD_W-1:0] MT_LIM = BCD_W'(MIN_LIMIT / 10);
  localparam logic [BCD_W-1:0] MO_LIM = BCD_W'(MIN_LIMIT % 10);

  logic      tick;
  state_t    state_q, state_nxt;
  bcd_time_t time_q, time_nxt;
  logic      wrap_q, wrap_nxt;

  tick_edge_sync u_tick_sync (
    .c     (c),
    .reset (reset),
    .d_in  (tick_in),
    .pulse (tick)
  );

  always_ff @(posedge c or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      time_q  <= '0;
      wrap_q  <= 1'b0;
    end else begin
      state_q <= state_nxt;
      time_q  <= time_nxt;
      wrap_q  <= wrap_nxt;
    end
  end

  always_comb begin
    state_nxt = state_q;
    time_nxt  = time_q;
    wrap_nxt  = 1'b0;

    if (clear) begin
      state_nxt = IDLE;
      time_nxt  = '0;
    end else begin
      if (start_stop) begin
        case (state_q)
          IDLE:    state_nxt = RUN;
          RUN:     state_nxt = PAUSE;
          PAUSE:   state_nxt = RUN;
          default: state_nxt = IDLE;
        endcase
      end

      // Gated on the registered state: a tick coinciding with the start
      // pulse is dropped, one coinciding with the stop pulse still counts.
      if (state_q == RUN && tick) begin
        if (time_q.sec_ones != 4'd9) begin
          time_nxt.sec_ones = time_q.sec_ones + 4'd1;
        end else begin
          time_nxt.sec_ones = '0;
          if (time_q.sec_tens != ST_MAX) begin
            time_nxt.sec_tens = time_q.sec_tens + 4'd1;
          end else begin
            time_nxt.sec_tens = '0;
            if (time_q.min_tens == MT_LIM && time_q.min_ones == MO_LIM) begin
              time_nxt.min_tens = '0;
              time_nxt.min_ones = '0;
              wrap_nxt          = 1'b1;
            end else if (time_q.min_ones != 4'd9) begin
              time_nxt.min_ones = time_q.min_ones + 4'd1;
            end else begin
              time_nxt.min_ones = '0;
              time_nxt.min_tens = time_q.min_tens + 4'd1;
            end
          end
        end
      end
    end
  end

  assign running = (state_q == RUN);
  assign digits  = time_q;
  assign wrap    = wrap_q;

`ifdef TICK_STOPWATCH_SEG_EN
  localparam logic [SCAN_BITS+1:0] SCAN_ONE = 1;

  logic [SCAN_BITS+1:0] scan_q;
  logic [1:0]           sel;
  logic [BCD_W-1:0]     cur;
  logic [3:0]           an_q;
  logic [6:0]           seg_q;

  // Top two bits of the free-running counter pick the digit slot;
  // slot 0 is the rightmost digit (sec_ones).
  assign sel = scan_q[SCAN_BITS+1 -: 2];

  always_comb begin
    cur = time_q.sec_ones;
    case (sel)
      2'd0:    cur = time_q.sec_ones;
      2'd1:    cur = time_q.sec_tens;
      2'd2:    cur = time_q.min_ones;
      default: cur = time_q.min_tens;
    endcase
  end

  // Counter is untouched by clear so the display cadence never jumps.
  always_ff @(posedge c or negedge reset) begin
    if (!reset) begin
      scan_q <= '0;
      an_q   <= 4'b1111;
      seg_q  <= 7'b1111111;
    end else begin
      scan_q <= scan_q + SCAN_ONE;
      an_q   <= ~(4'b0001 << sel);
      seg_q  <= seg7(cur);
    end
  end

  assign an  = an_q;
  assign seg = seg_q;
`else
  assign an  = 4'b1111;
  assign seg = 7'b1111111;
`endif

endmodule
